// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Fixed-latency data-memory responder for a load/store initiator.
//            Accepts one request while idle, waits LATENCY cycles, then
//            commits the store or returns the sign/zero-extended load data
//            with a single-cycle mem_ready strobe. Malformed or out-of-range
//            requests complete with mem_err and have no side effects.
// Ports    : clk          - single clock, rising edge
//            rst          - asynchronous reset, active low
//            mem_addr     - byte address
//            mem_we       - store request
//            mem_re       - load request
//            mem_op       - bit2 = store, bits[1:0] = size (byte/half/word)
//            mem_unsigned - load zero-extends when 1
//            mem_wdata    - right-aligned store data
//            mem_rdata    - registered, extended load result
//            mem_ready    - one-cycle response strobe
//            mem_err      - error flag, qualified by mem_ready
//            mem_busy     - high while a transaction is in flight
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [2:0]  mem_op,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        mem_busy
);

  localparam int         AW         = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_BUSY     = 2'd1;
  localparam logic [1:0] S_RESP     = 2'd2;
  localparam logic [3:0] C_CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [29:0] C_DEPTH   = 30'(DEPTH_WORDS);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [2:0]  r_op;
  logic        r_uns;
  logic [31:0] r_wdata;
  logic        r_re;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_from_in;
  logic [31:0] w_addr;
  logic [2:0]  w_op;
  logic        w_uns;
  logic [31:0] w_wdata;
  logic        w_re;
  logic        w_we;
  logic [1:0]  w_size;
  logic        w_err;
  logic        w_wr_en;
  logic [AW-1:0] w_idx;
  logic [31:0] w_rd_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wlane;

  assign w_accept = (r_state == S_IDLE) && (mem_re || mem_we);

  // With LATENCY=1 the accepting edge is also the edge entering RESP, so the
  // transaction fields must come straight from the ports in that case.
  assign w_enter_resp = (w_accept && (LATENCY == 1)) ||
                        ((r_state == S_BUSY) && (r_cnt == 4'd0));

  assign w_from_in = (r_state == S_IDLE);
  assign w_addr    = w_from_in ? mem_addr     : r_addr;
  assign w_op      = w_from_in ? mem_op       : r_op;
  assign w_uns     = w_from_in ? mem_unsigned : r_uns;
  assign w_wdata   = w_from_in ? mem_wdata    : r_wdata;
  assign w_re      = w_from_in ? mem_re       : r_re;
  assign w_we      = w_from_in ? mem_we       : r_we;
  assign w_size    = w_op[1:0];

  assign w_err = (w_re && w_we)                                  ||
                 (w_size == 2'b11)                               ||
                 ((w_size == 2'b01) && w_addr[0])                ||
                 ((w_size == 2'b10) && (w_addr[1:0] != 2'b00))   ||
                 (w_addr[31:2] >= C_DEPTH)                       ||
                 (w_op[2] != w_we);

  // Out-of-range addresses alias into the array here, but w_err already
  // suppresses both the write and the returned data for them.
  assign w_idx     = w_addr[AW+1:2];
  assign w_rd_word = r_mem[w_idx];

  always_comb begin
    w_byte = w_rd_word[7:0];
    case (w_addr[1:0])
      2'd0:    w_byte = w_rd_word[7:0];
      2'd1:    w_byte = w_rd_word[15:8];
      2'd2:    w_byte = w_rd_word[23:16];
      default: w_byte = w_rd_word[31:24];
    endcase
  end

  assign w_half = w_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_load = w_rd_word;
    case (w_size)
      2'b00:   w_load = w_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = w_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = w_rd_word;
    endcase
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = w_wdata;
    case (w_size)
      2'b00: begin
        w_be[w_addr[1:0]] = 1'b1;
        w_wlane           = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_wdata[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wlane = w_wdata;
      end
      default: begin
        w_be    = 4'b0000;
        w_wlane = w_wdata;
      end
    endcase
  end

  // rst gating keeps a request presented during reset from writing storage.
  assign w_wr_en = rst && w_enter_resp && w_we && !w_err;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= 32'd0;
      r_op      <= 3'd0;
      r_uns     <= 1'b0;
      r_wdata   <= 32'd0;
      r_re      <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= mem_addr;
            r_op    <= mem_op;
            r_uns   <= mem_unsigned;
            r_wdata <= mem_wdata;
            r_re    <= mem_re;
            r_we    <= mem_we;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
              r_cnt   <= 4'd0;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= C_CNT_LOAD;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_enter_resp) begin
        r_err <= w_err;
        // Stores leave the previous load result visible.
        if (w_err) begin
          mem_rdata <= 32'd0;
        end else if (w_re) begin
          mem_rdata <= w_load;
        end
      end
    end
  end

  assign mem_ready = (r_state == S_RESP);
  assign mem_err   = mem_ready && r_err;
  assign mem_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_addr  input  32  byte address from the load/store initiator.
REQ-006 SHALL have port mem_we  input  1  store request.
REQ-007 SHALL have port mem_re  input  1  load request.
REQ-008 SHALL have port mem_op  input  3  bit2=store, bits[1:0] size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port mem_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port mem_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port mem_rdata  output  32  registered, extended load result.
REQ-012 SHALL have port mem_ready  output  1  one-cycle response strobe.
REQ-013 SHALL have port mem_err  output  1  error flag, valid only with mem_ready.
REQ-014 SHALL have port mem_busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-016 SHALL accept a request only in IDLE, on an edge where mem_re or mem_we is 1, capturing addr, op, unsigned, wdata.
REQ-017 SHALL ignore mem_re/mem_we while in BUSY or RESP; initiator holds or drops them without effect.
REQ-018 SHALL on acceptance go to RESP if LATENCY=1, else to BUSY with counter loaded LATENCY-2.
REQ-019 SHALL in BUSY decrement counter each edge and go to RESP on the edge where counter is 0.
REQ-020 SHALL assert mem_ready for exactly the one RESP cycle, i.e. LATENCY cycles after the accepting edge; RESP always returns to IDLE next edge.
REQ-021 SHALL therefore sustain at most one transaction per LATENCY+1 cycles.
REQ-022 SHALL flag error (mem_err=1 with mem_ready) when: both mem_re and mem_we set; size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS; or mem_op[2] disagrees with mem_we.
REQ-023 SHALL on error perform no storage write and return mem_rdata=0.
REQ-024 SHALL commit stores on the edge entering RESP, with byte enables from size and addr[1:0] (byte lane addr[1:0], half lane addr[1]); other bytes unchanged.
REQ-025 SHALL register load data on the edge entering RESP, selecting lane by addr[1:0] and extending per mem_unsigned; word loads ignore mem_unsigned.
REQ-026 SHALL hold mem_rdata stable after RESP until the next load or error response; stores leave mem_rdata unchanged.
REQ-027 SHALL return the newly written value for a load issued after a store to the same address completes.
REQ-028 SHALL deassert mem_err in every non-RESP cycle.

Reset
REQ-029 SHALL on rst=0 immediately force state IDLE, counter 0, mem_ready 0, mem_err 0, mem_busy 0, mem_rdata 0.
REQ-030 SHALL leave storage contents unaffected by reset (not initialised).
REQ-031 SHALL abort an in-flight transaction if rst falls before the edge entering RESP: no write committed, no mem_ready.
REQ-032 SHALL accept a new request on the first rising edge with rst=1.

Verification
REQ-033 LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_ready 2 cycles after each accept, mem_err 0, mem_rdata 0xDEADBEEF.
REQ-034 After REQ-033: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-035 SB 0x11 data 0x00000055 then LW 0x10 -> 0xDEAD55EF.
REQ-036 LW 0x12, SH 0x11, mem_op=011, re+we together, addr 4*DEPTH_WORDS -> each mem_ready with mem_err 1, mem_rdata 0, following LW 0x10 unchanged.
REQ-037 Second request asserted during BUSY/RESP -> ignored, no extra mem_ready; request held into IDLE is accepted.
REQ-038 rst low one cycle after SW 0x20 data 0x12345678 accept -> no mem_ready, outputs 0; later LW 0x20 returns prior contents.
